// File: rtl/wide_mag_comp_seq.sv
// Sequential wide-operand magnitude comparator.
// One 4-bit comparator slice is reused to walk the operands MSB-first, one
// nibble per clock. The walk stops at the first unequal nibble. A full-width
// equal result takes NIB scan cycles.
//
// Handshake: start is a request that is accepted on any rising edge where
// busy=0 (state IDLE or DONE). a/b are sampled on that edge only. Starts
// while busy=1 are dropped, not queued. done is a one-cycle pulse. The flags
// and n_cmp stay valid from done until the next accepted start.
module wide_mag_comp_seq #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         a_gt_b,
  output logic                         a_lt_b,
  output logic                         a_eq_b,
  output logic [$clog2(WIDTH/4+1)-1:0] n_cmp,
  output logic [1:0]                   state_dbg
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW   = $clog2(NIB + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow_a;
  logic [WIDTH-1:0] shadow_b;
  logic [IDXW-1:0]  idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             slice_gt;
  logic             slice_lt;
  logic             slice_eq;
  logic             accept;

  // Status outputs decode straight from state, so reset clears them at once.
  always_comb begin
    busy      = (state == SCAN);
    done      = (state == DONE);
    state_dbg = state;
    accept    = start && (state != SCAN);
  end

  // Shared 4-bit comparator slice on the nibble selected by idx.
  always_comb begin
    nib_a    = shadow_a[4*idx +: 4];
    nib_b    = shadow_b[4*idx +: 4];
    slice_gt = (nib_a > nib_b);
    slice_lt = (nib_a < nib_b);
    slice_eq = (nib_a == nib_b);
  end

  // Control FSM, shadow operands, nibble index, result flags and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow_a <= '0;
      shadow_b <= '0;
      idx      <= '0;
      n_cmp    <= '0;
      a_gt_b   <= 1'b0;
      a_lt_b   <= 1'b0;
      a_eq_b   <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          n_cmp <= n_cmp + CW'(1);
          if (slice_gt) begin
            a_gt_b <= 1'b1;
            state  <= DONE;
          end else if (slice_lt) begin
            a_lt_b <= 1'b1;
            state  <= DONE;
          end else if (slice_eq && (idx == '0)) begin
            a_eq_b <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - IDXW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE falls back to IDLE.
          if (accept) begin
            shadow_a <= a;
            shadow_b <= b;
            idx      <= IDXW'(NIB - 1);
            n_cmp    <= '0;
            a_gt_b   <= 1'b0;
            a_lt_b   <= 1'b0;
            a_eq_b   <= 1'b0;
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
